// File: rtl/coin_acceptor.sv
// Coin chute front-end: synchronizes and debounces the raw nickel/dime sensors,
// classifies rising edges of the filtered levels into coin codes, queues them,
// and replays each as a HOLD-cycle code on `coin` followed by an idle gap.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned HOLD     = 1,
  parameter int unsigned GAP      = 2,
  parameter int unsigned DEPTH    = 4,
  localparam int unsigned PtrW    = $clog2(DEPTH),
  localparam int unsigned CntW    = PtrW + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            nickel_in,
  input  logic            dime_in,
  output logic [1:0]      coin,
  output logic            reject,
  output logic [CntW-1:0] pending
);

  typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

  // Channel vectors: bit 0 = nickel, bit 1 = dime. A rising-edge vector is
  // therefore already the coin code (01 nickel, 10 dime).
  logic [1:0]      raw;
  logic [1:0]      s1_q, s2_q;
  logic [1:0]      f_q, f_d;
  logic [1:0]      f_dly_q;
  logic [3:0]      db_cnt_q [2];
  logic [3:0]      db_cnt_d [2];
  logic [1:0]      rise;

  logic [1:0]      mem_q [DEPTH];
  logic [1:0]      mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop, full_after_pop;

  state_e          state_q, state_d;
  logic [2:0]      tmr_q, tmr_d;
  logic [1:0]      coin_q, coin_d;

  assign raw = {dime_in, nickel_in};

  // Debounce: the filtered level flips only after DEBOUNCE consecutive mismatches.
  always_comb begin
    f_d = f_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = 4'd0;
      if (s2_q[i] != f_q[i]) begin
        if (db_cnt_q[i] == 4'(DEBOUNCE - 1)) begin
          f_d[i] = ~f_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Synchronizer, debounce counters and filtered levels; filters reset high so
  // a sensor stuck high through reset is not counted as a coin.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q        <= 2'b00;
      s2_q        <= 2'b00;
      f_q         <= 2'b11;
      f_dly_q     <= 2'b11;
      db_cnt_q[0] <= 4'd0;
      db_cnt_q[1] <= 4'd0;
    end else begin
      s1_q        <= raw;
      s2_q        <= s1_q;
      f_q         <= f_d;
      f_dly_q     <= f_q;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  // Event classification and queue control; a same-cycle pop frees a slot.
  always_comb begin
    rise           = f_q & ~f_dly_q;
    pop            = (state_q == StIdle) && (count_q != '0);
    full_after_pop = (count_q == CntW'(DEPTH)) && !pop;
    push           = (rise == 2'b01 || rise == 2'b10) && !full_after_pop;
    reject         = (rise == 2'b11) || ((rise == 2'b01 || rise == 2'b10) && full_after_pop);
  end

  // Queue next state: pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = rise;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  // Queue storage and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'b00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Emitter: pop in idle, hold the code HOLD cycles, then GAP cycles of 00.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    coin_d  = coin_q;
    case (state_q)
      StIdle: begin
        coin_d = 2'b00;
        if (count_q != '0) begin
          coin_d  = mem_q[rd_ptr_q];
          tmr_d   = 3'(HOLD);
          state_d = StDrive;
        end
      end
      StDrive: begin
        tmr_d = tmr_q - 3'd1;
        if (tmr_q == 3'd1) begin
          coin_d  = 2'b00;
          tmr_d   = 3'(GAP);
          state_d = StGap;
        end
      end
      StGap: begin
        coin_d = 2'b00;
        tmr_d  = tmr_q - 3'd1;
        if (tmr_q == 3'd1) begin
          state_d = StIdle;
        end
      end
      default: begin
        coin_d  = 2'b00;
        tmr_d   = 3'd0;
        state_d = StIdle;
      end
    endcase
  end

  // Emitter state and registered coin code.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      tmr_q   <= 3'd0;
      coin_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      coin_q  <= coin_d;
    end
  end

  assign coin    = coin_q;
  assign pending = count_q;

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end for the newspaper vending controller. Takes raw, bouncy nickel and dime sensor lines from the mechanical coin chute, then synchronizes, debounces and classifies them. Queues detected coins and replays them as the one-clock `coin[1:0]` code pulses that `vend_ctrl` consumes, separated by idle gaps. Ambiguous coins, and coins arriving while the queue is full, are returned via `reject`.

## Interface
- `DEBOUNCE`, 4: consecutive cycles a synchronized sensor must differ from its filtered level before the filtered level flips (1..15).
- `HOLD`, 1: cycles each code is driven on `coin` (1..7).
- `GAP`, 2: cycles `coin` = 00 after each code before the next may start (1..7).
- `DEPTH`, 4: pending-coin queue entries (power of two, 2..16).

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `nickel_in`  in  1  raw 5-cent sensor, asynchronous, bouncy.
- `dime_in`  in  1  raw 10-cent sensor, asynchronous, bouncy.
- `coin`  out  2  coin code to `vend_ctrl`: 00 none, 01 nickel, 10 dime; 11 never driven.
- `reject`  out  1  one-cycle pulse; the coin is physically returned.
- `pending`  out  clog2(DEPTH)+1  queue occupancy.

## Operation
- Per channel: a 2-flop synchronizer (`s2` = second stage), a 4-bit debounce counter, and a filtered level `f`.
  - Counter clears whenever `s2 == f`.
  - Counter increments while `s2 != f`.
  - When the counter reaches DEBOUNCE, `f` toggles and the counter clears.
- Filtered level resets to 1. A sensor held high through reset produces no coin until it is seen low, then high again.
- Event = rising edge of `f`, combinational from `f` and its 1-cycle delayed copy.
- Event handling in the same cycle:
  - Nickel only: push 01.
  - Dime only: push 10.
  - Both: no push, `reject` = 1.
  - Push while full: the coin is dropped and `reject` = 1.
  - If a pop occurs in the same cycle, the full check uses occupancy after the pop, so push+pop at full is accepted and `pending` is unchanged.
- Queue: FIFO, DEPTH entries × 2 bits, with wrapping read/write pointers. `pending` = occupancy, 0..DEPTH.
- Emitter FSM (registered `coin`):
  - IDLE: `coin` = 00. If `pending` > 0: pop the head, load the code into `coin`, go to DRIVE with the hold count at HOLD.
  - DRIVE: `coin` = code. Decrement the count. When the count reaches 0: `coin` = 00, load GAP, go to GAP.
  - GAP: `coin` = 00. Decrement the count. When the count reaches 0, go to IDLE.
  - A queued coin therefore occupies exactly HOLD cycles of code plus at least GAP+1 cycles of 00. With the defaults, back-to-back codes repeat every 4 cycles.

## Timing
- Reset values (asynchronous, immediate on assert): `coin` = 00, `reject` = 0, `pending` = 0, FSM = IDLE, queue empty, counters 0, filtered levels 1, delayed copies 1.
- Reset mid-operation discards queued coins and any code being driven. `coin` drops to 00 without completing HOLD.
- Let E0 be the first rising edge that samples a raw input high, with the input stable afterwards:
  - `s2` is high after E1.
  - `f` rises after E(1+DEBOUNCE).
  - The push, or the `reject` pulse, occurs at E(2+DEBOUNCE). `reject` is high for exactly the cycle after E(1+DEBOUNCE).
  - With the FSM in IDLE and the queue empty, `coin` carries the code after E(3+DEBOUNCE). With defaults, that is 7 edges after E0.
- Any bounce shorter than DEBOUNCE cycles restarts the counter and produces no event.
- The falling edge of `f` produces no event.
- Nickel and dime events are judged simultaneous only when both `f` rise in the same cycle. A one-cycle offset gives two queued coins, nickel first if it rose first.
- Output changes only on rising `clock`, except under asynchronous reset.

## Test plan
- Reset, then a clean nickel pulse (raw high 8 cycles) -> `coin` = 01 for exactly 1 cycle, 7 edges after the first high sample; `pending` goes 0→1→0; `reject` stays 0.
- Dime with bounce (raw 1,0,1,0 per cycle, then stable high 8 cycles) -> exactly one `coin` = 10, no 01, no extra pulses.
- Nickel, nickel, dime arriving 2 cycles apart -> `coin` sequence 01, 00, 00, 00, 01, 00, 00, 00, 10, spaced 4 cycles; `pending` peaks at 2; `vend_ctrl` asserts `newspaper` after the dime.
- Six nickels faster than drain, with defaults -> `pending` reaches 4. Exactly the overflow arrivals pulse `reject`. `coin` emits 01 only for accepted coins (count of 01 pulses = 6 − reject pulses).
- Nickel and dime raw rising on the same edge -> `reject` = 1 for one cycle at E6; nothing queued; `coin` stays 00.
- `reset` asserted mid-DRIVE with 2 coins queued -> `coin` = 00 immediately, `pending` = 0. After release with `nickel_in` held high: no coin until the input goes low ≥4 cycles and high again.
